// File: rtl/wbq_pkg.sv
// Shared defaults and entry layout for the writeback queue.
package wbq_pkg;

   localparam int WBQ_DEPTH = 4;
   localparam int WBQ_AW    = 5;
   localparam int WBQ_DW    = 32;

   typedef struct packed {
      logic [WBQ_AW-1:0] rd;
      logic [WBQ_DW-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Result-in, register-file-write-out and operand-bypass signals of the writeback queue.
interface writeback_queue_if
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int AW    = WBQ_AW,
   parameter int DW    = WBQ_DW
);

   logic                   in_valid;
   logic                   in_ready;
   logic [AW-1:0]          in_rd;
   logic [DW-1:0]          in_data;
   logic                   rf_hold;
   logic                   rf_we;
   logic [AW-1:0]          rf_waddr;
   logic [DW-1:0]          rf_wdata;
   logic [AW-1:0]          rd_addr1;
   logic [AW-1:0]          rd_addr2;
   logic                   fwd_hit1;
   logic                   fwd_hit2;
   logic [DW-1:0]          fwd_data1;
   logic [DW-1:0]          fwd_data2;
   logic [$clog2(DEPTH):0] count;

   modport master (
      output in_valid, in_rd, in_data, rf_hold, rd_addr1, rd_addr2,
      input  in_ready, rf_we, rf_waddr, rf_wdata,
      input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
   );

   modport slave (
      input  in_valid, in_rd, in_data, rf_hold, rd_addr1, rd_addr2,
      output in_ready, rf_we, rf_waddr, rf_wdata,
      output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
   );

endinterface

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over age-ordered queue entries; purely combinational.
module wbq_fwd_match
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int AW    = WBQ_AW,
   parameter int DW    = WBQ_DW
) (
   input  wbq_entry_t       ent [DEPTH],
   input  logic [DEPTH-1:0] occ,
   input  logic [AW-1:0]    addr,
   output logic             hit,
   output logic [DW-1:0]    data
);

   // ent[0] is the oldest entry, so the last match in the scan is the youngest
   always_comb begin
      hit  = 1'b0;
      data = '0;
      if (addr != '0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (ent[i].rd[AW-1:0] == addr)) begin
               hit  = 1'b1;
               data = ent[i].data[DW-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// Queues datapath results for the register file write port with operand bypass.
// Head is written the cycle after acceptance; in_ready drops only on a full queue.
module writeback_queue
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int AW    = WBQ_AW,
   parameter int DW    = WBQ_DW
) (
   input logic              clk,
   input logic              reset,
   writeback_queue_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Entries use the package layout; AW/DW above the package widths are not supported
   wbq_entry_t       mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count_q;
   logic             not_full;
   logic             push;
   logic             pop;
   wbq_entry_t       ent_age [DEPTH];
   logic [DEPTH-1:0] occ;

   assign not_full = (count_q < CW'(DEPTH));

   // Results for r0 complete the handshake but are dropped here
   assign push = bus.in_valid && not_full && (bus.in_rd != '0) && !reset;
   assign pop  = (count_q != '0) && !bus.rf_hold && !reset;

   assign bus.in_ready = not_full || reset;
   assign bus.rf_we    = pop;
   assign bus.rf_waddr = pop ? mem[head].rd[AW-1:0]   : '0;
   assign bus.rf_wdata = pop ? mem[head].data[DW-1:0] : '0;
   assign bus.count    = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{rd: WBQ_AW'(bus.in_rd), data: WBQ_DW'(bus.in_data)};
      end
   end

   // Rotate storage so the search sees oldest-first; the head stays visible while being written
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_age[i] = mem[head + PW'(i)];
         occ[i]     = (CW'(i) < count_q) && !reset;
      end
   end

   wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
      .ent  (ent_age),
      .occ  (occ),
      .addr (bus.rd_addr1),
      .hit  (bus.fwd_hit1),
      .data (bus.fwd_data1)
   );

   wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
      .ent  (ent_age),
      .occ  (occ),
      .addr (bus.rd_addr2),
      .hit  (bus.fwd_hit2),
      .data (bus.fwd_data2)
   );

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: hand-written vector table, directed corner sequences, random vs queue model.
module tb_writeback_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   typedef struct {
      logic          we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          rdy;
      logic [2:0]    cnt;
      logic          h1;
      logic [DW-1:0] d1;
      logic          h2;
      logic [DW-1:0] d2;
   } outs_t;

   typedef struct {
      logic          r;
      logic          v;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      logic          h;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      outs_t         exp;
   } vec_t;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ment_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic          cur_r, cur_v, cur_h;
   logic [AW-1:0] cur_rd, cur_a1, cur_a2;
   logic [DW-1:0] cur_data;
   ment_t         mq[$];
   vec_t          vecs[$];

   writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

   writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic r, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                         input logic h, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      cur_r = r; cur_v = v; cur_rd = rd; cur_data = d; cur_h = h; cur_a1 = a1; cur_a2 = a2;
      reset        = r;
      bus.in_valid = v;
      bus.in_rd    = rd;
      bus.in_data  = d;
      bus.rf_hold  = h;
      bus.rd_addr1 = a1;
      bus.rd_addr2 = a2;
   endtask

   // Expected outputs from the pending-write list: oldest at front, youngest at back
   function automatic outs_t model_out();
      outs_t o;
      o = '{default: '0};
      o.cnt = 3'(mq.size());
      o.rdy = cur_r || (mq.size() < DEPTH);
      if (!cur_r && mq.size() > 0 && !cur_h) begin
         o.we    = 1'b1;
         o.waddr = mq[0].rd;
         o.wdata = mq[0].data;
      end
      if (!cur_r) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!o.h1 && cur_a1 != 0 && mq[i].rd == cur_a1) begin o.h1 = 1'b1; o.d1 = mq[i].data; end
            if (!o.h2 && cur_a2 != 0 && mq[i].rd == cur_a2) begin o.h2 = 1'b1; o.d2 = mq[i].data; end
         end
      end
      return o;
   endfunction

   task automatic model_update();
      int n;
      n = mq.size();
      if (cur_r) begin
         mq.delete();
      end else begin
         if (n > 0 && !cur_h) void'(mq.pop_front());
         if (cur_v && n < DEPTH && cur_rd != 0) mq.push_back('{cur_rd, cur_data});
      end
   endtask

   task automatic check_outs(input string tag, input outs_t e);
      chk({tag, ".rf_we"},     64'(bus.rf_we),     64'(e.we));
      chk({tag, ".rf_waddr"},  64'(bus.rf_waddr),  64'(e.waddr));
      chk({tag, ".rf_wdata"},  64'(bus.rf_wdata),  64'(e.wdata));
      chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(e.rdy));
      chk({tag, ".count"},     64'(bus.count),     64'(e.cnt));
      chk({tag, ".fwd_hit1"},  64'(bus.fwd_hit1),  64'(e.h1));
      chk({tag, ".fwd_data1"}, 64'(bus.fwd_data1), 64'(e.d1));
      chk({tag, ".fwd_hit2"},  64'(bus.fwd_hit2),  64'(e.h2));
      chk({tag, ".fwd_data2"}, 64'(bus.fwd_data2), 64'(e.d2));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic vec_t row(input logic r, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                                input logic h, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic rdy, input logic [2:0] cnt, input logic h1, input logic [DW-1:0] d1,
                                input logic h2, input logic [DW-1:0] d2);
      vec_t x;
      x.r = r; x.v = v; x.rd = rd; x.data = d; x.h = h; x.a1 = a1; x.a2 = a2;
      x.exp = '{we, wa, wd, rdy, cnt, h1, d1, h2, d2};
      return x;
   endfunction

   initial begin
      //                 r  v  rd data          h  a1 a2 | we wa wd           rdy cnt h1 d1           h2 d2
      vecs.push_back(row(0, 1, 5, 32'hAAAA0005, 0, 0, 0,   0, 0, 0,            1,  0,  0, 0,           0, 0));
      vecs.push_back(row(0, 0, 0, 0,            0, 5, 5,   1, 5, 32'hAAAA0005, 1,  1,  1, 32'hAAAA0005, 1, 32'hAAAA0005));
      vecs.push_back(row(0, 0, 0, 0,            0, 5, 0,   0, 0, 0,            1,  0,  0, 0,           0, 0));
      vecs.push_back(row(0, 1, 0, 32'hDEAD,     0, 0, 0,   0, 0, 0,            1,  0,  0, 0,           0, 0));
      vecs.push_back(row(0, 0, 0, 0,            0, 0, 0,   0, 0, 0,            1,  0,  0, 0,           0, 0));
      vecs.push_back(row(0, 1, 7, 32'h11,       1, 0, 0,   0, 0, 0,            1,  0,  0, 0,           0, 0));
      vecs.push_back(row(0, 1, 7, 32'h22,       1, 7, 0,   0, 0, 0,            1,  1,  1, 32'h11,      0, 0));
      vecs.push_back(row(0, 0, 0, 0,            1, 7, 0,   0, 0, 0,            1,  2,  1, 32'h22,      0, 0));
      vecs.push_back(row(0, 0, 0, 0,            1, 7, 7,   0, 0, 0,            1,  2,  1, 32'h22,      1, 32'h22));
      vecs.push_back(row(0, 1, 3, 32'h33,       1, 3, 7,   0, 0, 0,            1,  2,  0, 0,           1, 32'h22));
      vecs.push_back(row(0, 0, 0, 0,            1, 3, 7,   0, 0, 0,            1,  3,  1, 32'h33,      1, 32'h22));
      vecs.push_back(row(1, 1, 9, 32'h99,       0, 3, 7,   0, 0, 0,            1,  3,  0, 0,           0, 0));
      vecs.push_back(row(0, 0, 0, 0,            0, 3, 7,   0, 0, 0,            1,  0,  0, 0,           0, 0));
      vecs.push_back(row(0, 0, 0, 0,            0, 9, 0,   0, 0, 0,            1,  0,  0, 0,           0, 0));

      set_in(1, 0, 0, 0, 0, 0, 0);
      advance();

      for (int i = 0; i < vecs.size(); i++) begin
         set_in(vecs[i].r, vecs[i].v, vecs[i].rd, vecs[i].data, vecs[i].h, vecs[i].a1, vecs[i].a2);
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i].exp);
         advance();
      end

      // Fill under hold, refuse a fifth, then drain in order
      for (int i = 1; i <= 4; i++) begin
         set_in(0, 1, AW'(i), 32'h100 + i, 1, 0, 0);
         #1;
         check_outs("fill", model_out());
         advance();
      end
      set_in(0, 1, 5, 32'h105, 1, 0, 0);
      #1;
      chk("full.count", 64'(bus.count), 64'd4);
      chk("full.in_ready", 64'(bus.in_ready), 64'd0);
      advance();
      for (int i = 1; i <= 4; i++) begin
         set_in(0, 0, 0, 0, 0, AW'(i), 5);
         #1;
         chk($sformatf("drain%0d.we", i), 64'(bus.rf_we), 64'd1);
         chk($sformatf("drain%0d.waddr", i), 64'(bus.rf_waddr), 64'(i));
         chk($sformatf("drain%0d.wdata", i), 64'(bus.rf_wdata), 64'h100 + 64'(i));
         check_outs("drain", model_out());
         advance();
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("drained.count", 64'(bus.count), 64'd0);
      chk("drained.we", 64'(bus.rf_we), 64'd0);

      // Back-to-back pushes with the write port free: pointers wrap twice
      for (int i = 0; i < 10; i++) begin
         set_in(0, 1, AW'(i + 1), 32'hC000_0000 + i, 0, AW'(i), 0);
         #1;
         chk($sformatf("b2b%0d.cnt_le1", i), 64'(bus.count <= 1), 64'd1);
         if (i > 0) begin
            chk($sformatf("b2b%0d.waddr", i), 64'(bus.rf_waddr), 64'(i));
            chk($sformatf("b2b%0d.wdata", i), 64'(bus.rf_wdata), 64'hC000_0000 + 64'(i - 1));
         end
         check_outs("b2b", model_out());
         advance();
      end
      set_in(0, 0, 0, 0, 0, 10, 0);
      #1;
      chk("b2b_last.waddr", 64'(bus.rf_waddr), 64'd10);
      check_outs("b2b_last", model_out());
      advance();

      // Random traffic with small addresses to stress forwarding and r0 drops
      for (int n = 0; n < 600; n++) begin
         set_in(($urandom_range(49, 0) == 0), ($urandom_range(9, 0) < 6), AW'($urandom_range(7, 0)),
                $urandom, ($urandom_range(9, 0) < 3), AW'($urandom_range(7, 0)), AW'($urandom_range(7, 0)));
         #1;
         check_outs($sformatf("rnd%0d", n), model_out());
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
